// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up-counter with start/stop and clear, scanning one digit per SCAN_DIV
// cycles onto registered decoder outputs; optional leading-zero blanking.
module bcd_scan_counter #(
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 50_000,
   parameter int BLANK_LZ = 1
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start_stop,
   input  logic       clr,
   output logic [3:0] out_bcd,
   output logic       n_en,
   output logic [3:0] sel,
   output logic       carry
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

   logic            run;
   logic [PW-1:0]   p;
   logic [SW-1:0]   s;
   logic [1:0]      k;
   logic [3:0][3:0] dig;
   logic [3:0][3:0] dig_inc;
   logic            tick;
   logic            wrap;
   logic            z3, z2, z1;
   logic [3:0]      lz;
   logic            blank;

   assign tick = run && (p == P_LAST);

   // Ripple increment: the carry into each digit survives only while lower digits are 9.
   always_comb begin
      dig_inc = dig;
      wrap    = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (wrap) begin
            if (dig[i] == 4'd9) begin
               dig_inc[i] = 4'd0;
            end else begin
               dig_inc[i] = dig[i] + 4'd1;
               wrap       = 1'b0;
            end
         end
      end
   end

   // lz[i]: digit i and all higher digits are zero; digit 0 is never blanked.
   assign z3    = (dig[3] == 4'd0);
   assign z2    = z3 && (dig[2] == 4'd0);
   assign z1    = z2 && (dig[1] == 4'd0);
   assign lz    = {z3, z2, z1, 1'b0};
   assign blank = (BLANK_LZ != 0) && lz[k];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         run   <= 1'b0;
         p     <= '0;
         dig   <= '0;
         carry <= 1'b0;
      end else if (clr) begin
         run   <= 1'b0;
         p     <= '0;
         dig   <= '0;
         carry <= 1'b0;
      end else begin
         carry <= tick && wrap;
         if (tick) begin
            dig <= dig_inc;
         end
         if (run) begin
            p <= (p == P_LAST) ? '0 : p + PW'(1);
         end
         if (start_stop) begin
            run <= !run;
         end
      end
   end

   // Scanning is free-running and ignores run/clr.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s <= '0;
         k <= 2'd0;
      end else if (s == S_LAST) begin
         s <= '0;
         k <= k + 2'd1;
      end else begin
         s <= s + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         out_bcd <= 4'd0;
         n_en    <= 1'b1;
         sel     <= 4'b1111;
      end else begin
         out_bcd <= dig[k];
         n_en    <= blank;
         sel     <= ~(4'b0001 << k);
      end
   end
endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: integer reference model checked every cycle, a vector table
// of pulse/wait/expect steps, a 9999->0000 wrap sequence, and randomized pulses with a mid-run reset.
`timescale 1ns/1ps
module tb_bcd_scan_counter;
   localparam int TD = 4;
   localparam int SD = 2;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       start_stop;
   logic       clr;
   logic [3:0] out_bcd, sel, out_bcd0, sel0;
   logic       n_en, carry, n_en0, carry0;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   bcd_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
      .clk(clk), .n_rst(n_rst), .start_stop(start_stop), .clr(clr),
      .out_bcd(out_bcd), .n_en(n_en), .sel(sel), .carry(carry));

   bcd_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(0)) dut0 (
      .clk(clk), .n_rst(n_rst), .start_stop(start_stop), .clr(clr),
      .out_bcd(out_bcd0), .n_en(n_en0), .sel(sel0), .carry(carry0));

   always #5 clk = ~clk;

   function automatic int pow10(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
         if (errors >= 100) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   endtask

   // Reference model: the count is a plain integer 0..9999, digits derived by division.
   int       m_cnt, m_p, m_s, m_k;
   bit       m_run, m_nen, m_nen0, m_carry;
   bit [3:0] m_bcd, m_sel;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_cnt <= 0; m_p <= 0; m_s <= 0; m_k <= 0; m_run <= 0;
         m_bcd <= 4'd0; m_sel <= 4'hf; m_nen <= 1; m_nen0 <= 1; m_carry <= 0;
      end else begin
         m_bcd   <= 4'((m_cnt / pow10(m_k)) % 10);
         m_sel   <= 4'hf ^ (4'h1 << m_k);
         m_nen   <= (m_k != 0) && (m_cnt < pow10(m_k));
         m_nen0  <= 0;
         m_carry <= 0;
         if (clr) begin
            m_cnt <= 0; m_p <= 0; m_run <= 0;
         end else begin
            if (m_run) begin
               if (m_p == TD - 1) begin
                  m_p <= 0;
                  if (m_cnt == 9999) begin
                     m_cnt <= 0; m_carry <= 1;
                  end else begin
                     m_cnt <= m_cnt + 1;
                  end
               end else begin
                  m_p <= m_p + 1;
               end
            end
            if (start_stop) m_run <= !m_run;
         end
         m_s <= (m_s + 1) % SD;
         if (m_s == SD - 1) m_k <= (m_k + 1) % 4;
      end
   end

   always @(negedge clk) begin
      if (chk_on && n_rst) begin
         check("cycle_dut", int'({out_bcd, n_en, sel, carry}), int'({m_bcd, m_nen, m_sel, m_carry}));
         check("cycle_dut0", int'({out_bcd0, n_en0, sel0, carry0}), int'({m_bcd, m_nen0, m_sel, m_carry}));
      end
   end

   // Called at a negedge; the pulse is sampled by the next rising edge.
   task automatic pulse(input bit a, input bit b);
      start_stop = a;
      clr        = b;
      @(negedge clk);
      start_stop = 1'b0;
      clr        = 1'b0;
   endtask

   // Observe a full scan round and compare the displayed number and blanking pattern.
   task automatic read_display(input string tag, input int exp);
      int       d[4], d0[4];
      bit [3:0] bl, bl0, seen, bl_exp;
      int       j;
      seen = 0; bl = 0; bl0 = 0;
      for (int i = 0; i < 4; i++) begin d[i] = 0; d0[i] = 0; end
      repeat (10) begin
         @(negedge clk);
         case (sel)
            4'b1110: j = 0;
            4'b1101: j = 1;
            4'b1011: j = 2;
            4'b0111: j = 3;
            default: j = -1;
         endcase
         if (j >= 0) begin
            seen[j] = 1'b1;
            d[j]    = int'(out_bcd);
            bl[j]   = n_en;
            d0[j]   = int'(out_bcd0);
            bl0[j]  = n_en0;
         end
      end
      bl_exp = 4'b0000;
      for (int i = 1; i < 4; i++) bl_exp[i] = (exp < pow10(i));
      check({tag, "_seen"}, int'(seen), 15);
      check({tag, "_value"}, d[0] + 10*d[1] + 100*d[2] + 1000*d[3], exp);
      check({tag, "_blank"}, int'(bl), int'(bl_exp));
      check({tag, "_value_nolz"}, d0[0] + 10*d0[1] + 100*d0[2] + 1000*d0[3], exp);
      check({tag, "_blank_nolz"}, int'(bl0), 0);
   endtask

   typedef struct {
      bit ss;
      bit cl;
      int wait_cyc;
      bit chk;
      int exp;
   } vec_t;

   vec_t vecs[11];

   initial begin
      int hits;
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t required below 3000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      vecs[0]  = '{0, 1,   2, 1,  0};  // idle after clear
      vecs[1]  = '{1, 0, 160, 0,  0};  // start, 40 ticks
      vecs[2]  = '{1, 0,   0, 1, 40};  // stop with p=1
      vecs[3]  = '{1, 0,   2, 0,  0};  // restart, p advances to 3
      vecs[4]  = '{1, 0,   0, 1, 41};  // stop edge coincides with the tick
      vecs[5]  = '{1, 0,  36, 0,  0};  // 9 more ticks
      vecs[6]  = '{1, 0,   0, 1, 50};
      vecs[7]  = '{0, 1,   0, 1,  0};
      vecs[8]  = '{1, 0,  39, 0,  0};  // 0009 with next edge a tick
      vecs[9]  = '{1, 1,   0, 1,  0};  // clr beats tick and start_stop
      vecs[10] = '{0, 0,  20, 1,  0};  // stays stopped

      n_rst = 1'b0; start_stop = 1'b0; clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bcd", int'(out_bcd), 0);
      check("rst_n_en", int'(n_en), 1);
      check("rst_sel", int'(sel), 15);
      check("rst_carry", int'(carry), 0);
      check("rst_n_en_nolz", int'(n_en0), 1);
      n_rst = 1'b1;
      #1;
      check("rel_hold_sel", int'(sel), 15);
      @(negedge clk);
      check("first_sel", int'(sel), 14);
      check("first_n_en", int'(n_en), 0);
      check("first_bcd", int'(out_bcd), 0);
      chk_on = 1'b1;
      read_display("idle", 0);

      for (int v = 0; v < 11; v++) begin
         pulse(vecs[v].ss, vecs[v].cl);
         repeat (vecs[v].wait_cyc) @(negedge clk);
         if (vecs[v].chk) read_display($sformatf("vec%0d", v), vecs[v].exp);
      end

      // 9998 ticks, then two more: carry pulses once on 9999->0000.
      pulse(1'b1, 1'b0);
      repeat (9998 * TD) @(negedge clk);
      hits = 0;
      repeat (2 * TD) begin
         @(negedge clk);
         if (carry) hits++;
      end
      check("wrap_carry_pulses", hits, 1);
      pulse(1'b1, 1'b0);
      check("wrap_carry_low", int'(carry), 0);
      read_display("wrap", 0);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start_stop = ($urandom_range(0, 15) == 0);
         clr        = ($urandom_range(0, 150) == 0);
         if (c == 1500) begin
            #2 n_rst = 1'b0;
            #1;
            check("async_rst_bcd", int'(out_bcd), 0);
            check("async_rst_n_en", int'(n_en), 1);
            check("async_rst_sel", int'(sel), 15);
            check("async_rst_carry", int'(carry), 0);
            @(negedge clk);
            n_rst = 1'b1;
         end
      end
      start_stop = 1'b0;
      clr        = 1'b0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Four-digit BCD up-counter with time-multiplexed display scanning, sitting directly upstream of the 7-segment decoder stage. Each cycle it presents one digit's BCD code and an active-low blank/enable to the decoder, plus an active-low one-hot digit select for the common-cathode display bank. Counting is gated by a start/stop toggle and a synchronous clear. Optional leading-zero blanking drives the decoder enable high for insignificant digits.

## Interface
Parameters:
- TICK_DIV, 50_000_000: clock cycles per count increment; legal values ≥ 2.
- SCAN_DIV, 50_000: clock cycles each digit stays selected; legal values ≥ 2.
- BLANK_LZ, 1: 1 = blank leading zeros on digits 3..1; 0 = never blank.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- n_rst  in  1  asynchronous active-low reset.
- start_stop  in  1  single-cycle pulse; toggles run state.
- clr  in  1  single-cycle pulse; synchronous clear.
- out_bcd  out  4  BCD code of the currently scanned digit; drives decoder `in`.
- n_en  out  1  active-low decoder enable; 1 blanks the current digit.
- sel  out  4  active-low one-hot digit select; sel[i]=0 selects digit i (digit 0 = least significant).
- carry  out  1  one-cycle pulse on 9999→0000 wrap.

## Operation
- State: run flag; prescaler p (0..TICK_DIV-1); digits d3..d0, each 0..9; scan divider s (0..SCAN_DIV-1); scan index k (0..3). All counter widths are $clog2 of their range.
- Run flag: start_stop toggles it. clr forces it to 0. clr wins over a simultaneous start_stop.
- Prescaler: while run=1, p increments and wraps at TICK_DIV-1. The cycle with p==TICK_DIV-1 is a tick. While run=0, p holds its value; it does not reset.
- Tick: d0 increments. A digit at 9 wraps to 0 and increments the next digit (ripple within the same cycle). When 9999 wraps to 0000, carry=1 for exactly that cycle.
- clr: digits←0, p←0, run←0, carry←0. clr overrides a coincident tick: no increment and no carry.
- Scan: s increments every cycle regardless of run or clr. When s==SCAN_DIV-1, s←0 and k←(k+1) mod 4 (sequence 0,1,2,3,0…).
- Blanking, with BLANK_LZ=1: digit k (k≥1) is blank when d[k] and every higher digit are all 0. Digit 0 is never blank. With BLANK_LZ=0, nothing is blank.
- Output registers, loaded every cycle from current state:
  - out_bcd←d[k]
  - sel←~(4'b0001<<k)
  - n_en←blank(k)
- out_bcd keeps the digit value when blanked. The decoder ignores it.

## Timing
- Reset (n_rst=0, asynchronous): run=0, p=0, s=0, k=0, all digits 0; out_bcd=0, n_en=1, sel=4'b1111, carry=0. Outputs hold these values until the first clock edge after reset release.
- First edge after release: sel=4'b1110, out_bcd=0, n_en=0 (digit 0 is never blanked).
- Latency: a digit change or k change at edge N shows on out_bcd/sel/n_en at edge N+1.
- sel, out_bcd and n_en always update on the same edge, so no cycle shows a mismatched digit.
- Counting: from the start_stop pulse at edge N, the first tick is at edge N+TICK_DIV (p starts from its held value; from 0 this is TICK_DIV cycles).
- carry asserts on the same edge the digits become 0000 and deasserts on the next edge.
- Reset asserted mid-count or mid-scan returns everything to the reset values immediately. It does not wait for a clock edge.

## Test plan
- Reset/idle: hold n_rst=0 then release, no start pulse → sel=1110 immediately after reset, then cycles 1110,1101,1011,0111 every SCAN_DIV clocks. Digit 0 has n_en=0 and out_bcd=0; digits 1–3 have n_en=1 (BLANK_LZ=1). Digits never change.
- Count/ripple (TICK_DIV=4, SCAN_DIV=2): pulse start_stop, run 40 ticks → digits read 0040. On scan, digit1 shows out_bcd=4, n_en=0; digit0 shows 0, n_en=0; digits 2–3 have n_en=1.
- Wrap: preload to 9998 by running 9998 ticks, then run 2 more ticks → carry is high for exactly one cycle at 9999→0000; all digits read 0; digits 1–3 blanked.
- Stop/resume: stop at 0012 with p mid-count (p=2), wait 100 cycles, restart → digits remain 0012 while stopped; the next tick arrives TICK_DIV-2 cycles after the restart.
- clr priority: assert clr coincident with both a tick and a start_stop pulse at 0009 → digits become 0000, run=0, carry stays 0, no further counting.
- BLANK_LZ=0 at count 0005 → all four digits have n_en=0; out_bcd reads 5,0,0,0 for k=0..3.
